// File: rtl/hfrv_trace_buffer.sv
// Retirement-trace capture buffer for HF-RISC: filtered/triggered capture, valid/ready drain.
// Optional macro TRACE_TIMESTAMP_EN adds a per-entry cycle timestamp (out_ts).
module hfrv_trace_buffer #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int STOP_AFTER = 0,
  parameter int TS_W       = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_mode,
  input  logic [31:0]              cfg_opc_en,
  input  logic                     cfg_trig_en,
  input  logic [XLEN-1:0]          cfg_trig_pc,
  input  logic                     arm,
  input  logic                     ret_valid,
  input  logic [XLEN-1:0]          ret_pc,
  input  logic [31:0]              ret_instr,
  input  logic                     ret_we,
  input  logic [4:0]               ret_rd,
  input  logic [XLEN-1:0]          ret_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_we,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_wdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              dropped,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]          out_ts,
`endif
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [31:0]   STOP_LAST = (STOP_AFTER > 0) ? 32'(STOP_AFTER - 1) : 32'd0;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_param_err
    $error("hfrv_trace_buffer: DEPTH must be a power of 2 >= 2 and TS_W >= 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     dropped_q, dropped_d;
  logic [31:0]     cnt_q, cnt_d;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic            we_mem    [DEPTH];
  logic [4:0]      rd_mem    [DEPTH];
  logic [XLEN-1:0] wdata_mem [DEPTH];

  logic qual, trig_hit, push, full, pop, wr_en, rd_adv, drop_inc, we_st;

  assign qual     = ret_valid && cfg_opc_en[ret_instr[6:2]];
  assign trig_hit = ret_valid && (ret_pc == cfg_trig_pc);
  // The trigger instruction itself opens the capture window.
  assign push     = !arm && qual &&
                    ((state_q == CAPTURE) || (state_q == ARMED && trig_hit));
  assign full     = (level_q == FULL_LVL);
  assign pop      = out_valid && out_ready && !arm;
  assign wr_en    = push && (!full || pop || cfg_mode);
  assign rd_adv   = pop || (wr_en && full);
  assign drop_inc = push && full && !pop;
  assign we_st    = ret_we && (ret_rd != 5'd0);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    dropped_d = dropped_q;
    cnt_d     = cnt_q;
    if (arm) begin
      state_d   = cfg_trig_en ? ARMED : CAPTURE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      dropped_d = '0;
      cnt_d     = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(rd_adv);
      level_d  = level_q + LW'(wr_en) - LW'(rd_adv);
      if (drop_inc && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
      if (wr_en) cnt_d = cnt_q + 32'd1;
      if (state_q == ARMED && trig_hit) state_d = CAPTURE;
      if (STOP_AFTER > 0 && wr_en && cnt_q == STOP_LAST) state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      dropped_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      dropped_q <= dropped_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]    <= ret_pc;
      instr_mem[wr_ptr_q] <= ret_instr;
      we_mem[wr_ptr_q]    <= we_st;
      rd_mem[wr_ptr_q]    <= ret_rd;
      wdata_mem[wr_ptr_q] <= we_st ? ret_wdata : '0;
    end
  end

  // Gate data with out_valid so an empty buffer always presents zeros.
  assign out_valid = (level_q != '0);
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
  assign out_we    = out_valid ? we_mem[rd_ptr_q]    : 1'b0;
  assign out_rd    = out_valid ? rd_mem[rd_ptr_q]    : '0;
  assign out_wdata = out_valid ? wdata_mem[rd_ptr_q] : '0;
  assign level     = level_q;
  assign dropped   = dropped_q;
  assign state     = state_q;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) ts_mem[wr_ptr_q] <= ts_q;
  end

  assign out_ts = out_valid ? ts_mem[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_hfrv_trace_buffer.sv
// Self-checking bench for hfrv_trace_buffer: directed plan steps, then random traffic vs a queue model.
module tb_hfrv_trace_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cfg_mode, cfg_trig_en, arm, ret_valid, ret_we, out_ready;
  logic [31:0] cfg_opc_en, cfg_trig_pc, ret_pc, ret_instr, ret_wdata;
  logic [4:0]  ret_rd;

  logic        out_valid, out_we;
  logic [31:0] out_pc, out_instr, out_wdata;
  logic [4:0]  out_rd;
  logic [4:0]  level;
  logic [15:0] dropped;
  logic [1:0]  state;

  logic        s_out_valid, s_out_we;
  logic [31:0] s_out_pc, s_out_instr, s_out_wdata;
  logic [4:0]  s_out_rd;
  logic [4:0]  s_level;
  logic [15:0] s_dropped;
  logic [1:0]  s_state;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] out_ts, s_out_ts;
`endif

  hfrv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .STOP_AFTER(0)) u_dut (
    .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .cfg_opc_en(cfg_opc_en),
    .cfg_trig_en(cfg_trig_en), .cfg_trig_pc(cfg_trig_pc), .arm(arm),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_we(ret_we),
    .ret_rd(ret_rd), .ret_wdata(ret_wdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_we(out_we), .out_rd(out_rd),
    .out_wdata(out_wdata), .level(level), .dropped(dropped),
`ifdef TRACE_TIMESTAMP_EN
    .out_ts(out_ts),
`endif
    .state(state));

  hfrv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .STOP_AFTER(2)) u_stop (
    .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .cfg_opc_en(cfg_opc_en),
    .cfg_trig_en(cfg_trig_en), .cfg_trig_pc(cfg_trig_pc), .arm(arm),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_we(ret_we),
    .ret_rd(ret_rd), .ret_wdata(ret_wdata), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_out_pc), .out_instr(s_out_instr), .out_we(s_out_we), .out_rd(s_out_rd),
    .out_wdata(s_out_wdata), .level(s_level), .dropped(s_dropped),
`ifdef TRACE_TIMESTAMP_EN
    .out_ts(s_out_ts),
`endif
    .state(s_state));

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] ts;
  } ent_t;

  // Model: main buffer as a queue; the STOP_AFTER=2 instance only tracks occupancy and state.
  ent_t        mq[$];
  int          m_drop, m_st;
  int          s_lvl, s_st, s_cnt;
  int unsigned m_ts;
  int          n_pass = 0, n_fail = 0, n_tot = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic qual, hit;
    ent_t e;
    if (reset) begin
      mq.delete(); m_drop = 0; m_st = 0; m_ts = 0;
      s_lvl = 0; s_st = 0; s_cnt = 0;
      return;
    end
    e.ts = m_ts;
    m_ts++;
    if (arm) begin
      mq.delete(); m_drop = 0; m_st = cfg_trig_en ? 1 : 2;
      s_lvl = 0; s_cnt = 0; s_st = m_st;
      return;
    end
    qual    = ret_valid && cfg_opc_en[ret_instr[6:2]];
    hit     = ret_valid && (ret_pc == cfg_trig_pc);
    e.pc    = ret_pc;
    e.instr = ret_instr;
    e.we    = ret_we && (ret_rd != 0);
    e.rd    = ret_rd;
    e.wdata = e.we ? ret_wdata : 32'd0;

    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    if (m_st == 1 && hit) m_st = 2;
    if (m_st == 2 && qual) begin
      if (mq.size() < DEPTH) mq.push_back(e);
      else begin
        if (cfg_mode) begin void'(mq.pop_front()); mq.push_back(e); end
        if (m_drop < 65535) m_drop++;
      end
    end

    if (s_lvl > 0 && out_ready) s_lvl--;
    if (s_st == 1 && hit) s_st = 2;
    if (s_st == 2 && qual) begin
      if (s_lvl < DEPTH) begin s_lvl++; s_cnt++; end
      else if (cfg_mode) s_cnt++;
      if (s_cnt == 2) s_st = 3;
    end
  endtask

  task automatic check_all();
    ent_t h;
    h = '0;
    if (mq.size() > 0) h = mq[0];
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("out_pc",    64'(out_pc),    64'(h.pc));
    chk("out_instr", 64'(out_instr), 64'(h.instr));
    chk("out_we",    64'(out_we),    64'(h.we));
    chk("out_rd",    64'(out_rd),    64'(h.rd));
    chk("out_wdata", 64'(out_wdata), 64'(h.wdata));
    chk("level",     64'(level),     64'(mq.size()));
    chk("dropped",   64'(dropped),   64'(m_drop));
    chk("state",     64'(state),     64'(m_st));
    chk("stop_state", 64'(s_state),  64'(s_st));
    chk("stop_level", 64'(s_level),  64'(s_lvl));
    chk("stop_valid", 64'(s_out_valid), 64'(s_lvl > 0));
`ifdef TRACE_TIMESTAMP_EN
    chk("out_ts",    64'(out_ts),    64'(h.ts));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_arm(input logic trig);
    cfg_trig_en = trig;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                        input logic [4:0] rd, input logic [31:0] wdata);
    ret_valid = 1'b1; ret_pc = pc; ret_instr = instr;
    ret_we = we; ret_rd = rd; ret_wdata = wdata;
    tick();
    ret_valid = 1'b0;
  endtask

  localparam logic [31:0] ADDI_X1 = 32'h00100093;
  localparam logic [31:0] LUI_X2  = 32'h00002137;
  localparam logic [31:0] ADDI_X0 = 32'h00100013;

  initial begin
    logic [31:0] r, ts_a;
    reset = 1'b1; cfg_mode = 1'b0; cfg_opc_en = '1; cfg_trig_en = 1'b0;
    cfg_trig_pc = 32'h100; arm = 1'b0; ret_valid = 1'b0; ret_pc = '0;
    ret_instr = '0; ret_we = 1'b0; ret_rd = '0; ret_wdata = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    reset = 1'b0;
    tick();

    // Basic capture, latency 1, ordered pop
    do_arm(1'b0);
    chk("arm_empty", 64'(out_valid), 64'd0);
    retire(32'h40, ADDI_X1, 1'b1, 5'd1, 32'h11);
    chk("lat1_valid", 64'(out_valid), 64'd1);
    retire(32'h44, ADDI_X1, 1'b1, 5'd1, 32'h22);
    retire(32'h48, ADDI_X1, 1'b1, 5'd1, 32'h33);
    chk("lvl3", 64'(level), 64'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("pop_order", 64'(out_pc), 64'(32'h40 + 4 * i));
      tick();
    end
    out_ready = 1'b0;

    // Opcode-class filter
    cfg_opc_en = 32'h10;
    do_arm(1'b0);
    retire(32'h200, ADDI_X1, 1'b1, 5'd1, 32'h5);
    retire(32'h204, LUI_X2, 1'b1, 5'd2, 32'h2000);
    chk("filt_lvl", 64'(level), 64'd1);
    chk("filt_drop", 64'(dropped), 64'd0);
    chk("filt_pc", 64'(out_pc), 64'h200);

    // PC trigger
    cfg_opc_en = '1;
    do_arm(1'b1);
    chk("trig_armed", 64'(state), 64'd1);
    retire(32'hF8, ADDI_X1, 1'b0, 5'd0, 32'h0);
    retire(32'hFC, ADDI_X1, 1'b0, 5'd0, 32'h0);
    chk("trig_wait", 64'(level), 64'd0);
    retire(32'h100, ADDI_X1, 1'b0, 5'd0, 32'h0);
    chk("trig_cap", 64'(state), 64'd2);
    retire(32'h104, ADDI_X1, 1'b0, 5'd0, 32'h0);
    chk("trig_lvl", 64'(level), 64'd2);
    chk("trig_head", 64'(out_pc), 64'h100);

    // Full, mode 0: drop newest; then simultaneous push+pop when full
    cfg_mode = 1'b0;
    do_arm(1'b0);
    for (int i = 0; i < 20; i++) retire(32'h1000 + 4 * i, ADDI_X1, 1'b1, 5'd3, i);
    chk("m0_lvl", 64'(level), 64'd16);
    chk("m0_drop", 64'(dropped), 64'd4);
    chk("m0_head", 64'(out_pc), 64'h1000);
    chk("stop_done", 64'(s_state), 64'd3);
    chk("stop_lvl", 64'(s_level), 64'd2);
    out_ready = 1'b1;
    retire(32'h2000, ADDI_X1, 1'b1, 5'd3, 32'h0);
    out_ready = 1'b0;
    chk("pp_lvl", 64'(level), 64'd16);
    chk("pp_drop", 64'(dropped), 64'd4);
    chk("pp_head", 64'(out_pc), 64'h1004);

    // Full, mode 1: overwrite oldest
    cfg_mode = 1'b1;
    do_arm(1'b0);
    for (int i = 0; i < 20; i++) retire(32'h1000 + 4 * i, ADDI_X1, 1'b1, 5'd3, i);
    chk("m1_lvl", 64'(level), 64'd16);
    chk("m1_drop", 64'(dropped), 64'd4);
    chk("m1_head", 64'(out_pc), 64'h1010);
    cfg_mode = 1'b0;

    // STOP_AFTER=2 instance reaches DONE on the 2nd capture and ignores later ones
    do_arm(1'b0);
    retire(32'h300, ADDI_X0, 1'b1, 5'd0, 32'hDEAD);
    chk("x0_we", 64'(out_we), 64'd0);
    chk("x0_wdata", 64'(out_wdata), 64'd0);
    chk("stop_one", 64'(s_state), 64'd2);
    retire(32'h304, ADDI_X1, 1'b1, 5'd1, 32'h7);
    chk("stop_two", 64'(s_state), 64'd3);
    retire(32'h308, ADDI_X1, 1'b1, 5'd1, 32'h8);
    chk("stop_ign", 64'(s_level), 64'd2);

`ifdef TRACE_TIMESTAMP_EN
    do_arm(1'b0);
    retire(32'h400, ADDI_X1, 1'b0, 5'd0, 32'h0);
    ts_a = out_ts;
    tick(); tick();
    retire(32'h40C, ADDI_X1, 1'b0, 5'd0, 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ts_delta", 64'(out_ts - ts_a), 64'd3);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      reset     = (r[7:0] == 8'd0);
      arm       = (r[13:8] < 6'd2);
      if (arm) begin
        cfg_trig_en = r[14];
        cfg_mode    = r[15];
        if (r[16]) cfg_opc_en = $urandom;
        else       cfg_opc_en = '1;
      end
      ret_valid = (r[18:17] != 2'd0);
      r = $urandom;
      ret_pc    = (r[2:0] == 3'd0) ? 32'h100 : {20'd0, r[11:2], 2'b00};
      r = $urandom;
      ret_instr = {r[31:7], r[6:2], 2'b11};
      r = $urandom;
      ret_we    = r[0];
      ret_rd    = r[5:1];
      out_ready = (i % 100 < 50) ? (r[8:6] == 3'd0) : r[6];
      ret_wdata = $urandom;
      tick();
    end
    reset = 1'b0; arm = 1'b0; ret_valid = 1'b0; out_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
